l2_responder: RTL and testbench

L2_RESPONDER -- requirements
Module: l2_responder

---
 rtl/l2_responder.sv | 104 ++++++++++
 tb/tb_l2_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_responder.sv
// Fixed-latency L2 backing store answering LOAD / STORE / CLFLUSH word requests.
// The memory array has no reset, so its contents survive reset.
package xentry_pkg;
   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      STORE   = 2'd1,
      CLFLUSH = 2'd2
   } memory_operation_e;
endpackage

module l2_responder
   import xentry_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MEM_SIZE = 4096,
   parameter int LATENCY  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   l2_req_address,
   input  memory_operation_e l2_req_type,
   input  logic              l2_req_valid,
   input  logic [XLEN-1:0]   l2_word_to_store,
   output logic [XLEN-1:0]   l2_fetched_word,
   output logic              l2_fetched_word_valid,
   output logic              protocol_error
);
   localparam int BYTES = XLEN / 8;
   localparam int WORDS = MEM_SIZE / BYTES;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e            state, state_nxt;
   logic [7:0]        cnt;
   logic [XLEN-1:0]   cap_addr, cap_data;
   memory_operation_e cap_type;
   logic [XLEN-1:0]   mem [WORDS];
   logic [IDX_W-1:0]  idx;
   logic              done, mismatch;

   // Byte offset and bits above MEM_SIZE drop out here, giving the address wrap.
   assign idx = cap_addr[OFF_W +: IDX_W];

   assign mismatch = !l2_req_valid
                  || (l2_req_address   != cap_addr)
                  || (l2_req_type      != cap_type)
                  || (l2_word_to_store != cap_data);

   always_comb begin
      state_nxt             = state;
      done                  = 1'b0;
      l2_fetched_word_valid = 1'b0;
      case (state)
         IDLE: if (l2_req_valid) state_nxt = WAIT;
         WAIT: if (cnt == 8'd1) begin
            state_nxt = RESP;
            done      = 1'b1;
         end
         RESP: begin
            state_nxt             = IDLE;
            l2_fetched_word_valid = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         cnt             <= '0;
         cap_addr        <= '0;
         cap_data        <= '0;
         cap_type        <= LOAD;
         l2_fetched_word <= '0;
         protocol_error  <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (l2_req_valid) begin
               cap_addr <= l2_req_address;
               cap_type <= l2_req_type;
               cap_data <= l2_word_to_store;
               cnt      <= 8'(LATENCY);
            end
            // The transaction always finishes on the captured fields; a
            // wobbling initiator only raises the sticky flag.
            WAIT: begin
               cnt <= cnt - 8'd1;
               if (mismatch) protocol_error <= 1'b1;
            end
            default: ;
         endcase
         if (done && cap_type == LOAD) l2_fetched_word <= mem[idx];
      end
   end

   // done is only possible in WAIT, which reset forces away immediately,
   // so an aborted STORE never reaches the array.
   always_ff @(posedge clk) begin
      if (done && cap_type == STORE) mem[idx] <= cap_data;
   end
endmodule

// File: tb/tb_l2_responder.sv
// Random + directed bench for l2_responder against a timestamp-based reference model.
module tb_l2_responder;
   import xentry_pkg::*;

   localparam int XLEN     = 32;
   localparam int MEM_SIZE = 4096;
   localparam int LATENCY  = 4;
   localparam int BYTES    = XLEN / 8;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [XLEN-1:0]   l2_req_address = '0;
   memory_operation_e l2_req_type = LOAD;
   logic              l2_req_valid = 1'b0;
   logic [XLEN-1:0]   l2_word_to_store = '0;
   logic [XLEN-1:0]   l2_fetched_word;
   logic              l2_fetched_word_valid;
   logic              protocol_error;

   l2_responder #(.XLEN(XLEN), .MEM_SIZE(MEM_SIZE), .LATENCY(LATENCY)) dut (
      .clk                  (clk),
      .reset                (reset),
      .l2_req_address       (l2_req_address),
      .l2_req_type          (l2_req_type),
      .l2_req_valid         (l2_req_valid),
      .l2_word_to_store     (l2_word_to_store),
      .l2_fetched_word      (l2_fetched_word),
      .l2_fetched_word_valid(l2_fetched_word_valid),
      .protocol_error       (protocol_error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request is a record with an absolute due edge; the
   // store is a sparse map of words whose value the bench knows.
   logic [XLEN-1:0]   mm [int];
   bit                pend;
   longint            e, due, free_at;
   logic [XLEN-1:0]   p_addr, p_data;
   memory_operation_e p_type;
   logic [XLEN-1:0]   m_fetched;
   bit                m_fk, m_err, m_strobe;

   function automatic int widx(input logic [XLEN-1:0] a);
      return int'((a % MEM_SIZE) / BYTES);
   endfunction

   task automatic model_reset();
      pend = 0; free_at = 0; m_fetched = '0; m_fk = 1; m_err = 0; m_strobe = 0;
   endtask

   task automatic model_step();
      e++;
      m_strobe = 0;
      if (pend) begin
         if (!l2_req_valid || l2_req_address !== p_addr || l2_req_type !== p_type
             || l2_word_to_store !== p_data) m_err = 1;
         if (e == due) begin
            if (p_type == STORE) mm[widx(p_addr)] = p_data;
            else if (p_type == LOAD) begin
               if (mm.exists(widx(p_addr))) begin m_fetched = mm[widx(p_addr)]; m_fk = 1; end
               else m_fk = 0;
            end
            m_strobe = 1;
            pend = 0;
         end
      end else if (e >= free_at && l2_req_valid) begin
         pend = 1; p_addr = l2_req_address; p_type = l2_req_type; p_data = l2_word_to_store;
         due = e + LATENCY;
         free_at = e + LATENCY + 2;
      end
   endtask

   initial begin
      e = 0;
      model_reset();
      forever begin
         @(posedge clk);
         if (!reset) model_reset(); else model_step();
         @(negedge clk);
         if (!reset) model_reset();
         chk("valid", l2_fetched_word_valid, m_strobe);
         chk("protocol_error", protocol_error, m_err);
         if (m_fk) chk("fetched_word", l2_fetched_word, m_fetched);
      end
   end

   task automatic drive(input logic [XLEN-1:0] a, input memory_operation_e t, input logic [XLEN-1:0] d);
      l2_req_address = a; l2_req_type = t; l2_word_to_store = d; l2_req_valid = 1'b1;
   endtask

   // Waits for the strobe at negedges; n counts rising edges since the call.
   task automatic wait_strobe(output int n);
      bit ok = 0;
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (l2_fetched_word_valid) begin ok = 1; break; end
         @(posedge clk);
         n++;
      end
      if (!ok) chk("strobe_timeout", 0, 1);
   endtask

   // Issue one request from IDLE; lat = edges from accepting edge to strobe.
   task automatic do_req(input logic [XLEN-1:0] a, input memory_operation_e t,
                         input logic [XLEN-1:0] d, output int lat);
      @(posedge clk); #1 drive(a, t, d);
      @(posedge clk);
      wait_strobe(lat);
      @(posedge clk); #1 l2_req_valid = 1'b0;
   endtask

   initial begin
      int     lat;
      time    t_prev, t_now;
      int     strobes;
      memory_operation_e rt;
      logic [XLEN-1:0] ra;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", l2_fetched_word_valid, 0);
      chk("reset_fetched", l2_fetched_word, 0);
      chk("reset_perr", protocol_error, 0);
      @(posedge clk); #1 reset = 1'b1;

      // store then load, fixed latency
      do_req(32'h40, STORE, 32'hDEAD_BEEF, lat);
      chk("store_latency", lat, LATENCY);
      do_req(32'h40, LOAD, 32'h0, lat);
      chk("load_latency", lat, LATENCY);
      chk("load_40", l2_fetched_word, 32'hDEAD_BEEF);
      // wrap and ignored byte offset
      do_req(32'h1040, LOAD, 32'h0, lat);
      chk("load_wrap", l2_fetched_word, 32'hDEAD_BEEF);
      do_req(32'h42, LOAD, 32'h0, lat);
      chk("load_offset", l2_fetched_word, 32'hDEAD_BEEF);

      // CLFLUSH leaves both the word and the fetched register alone
      do_req(32'h44, STORE, 32'h4444_4444, lat);
      do_req(32'h44, LOAD, 32'h0, lat);
      do_req(32'h40, CLFLUSH, 32'h0, lat);
      chk("clflush_latency", lat, LATENCY);
      chk("clflush_hold", l2_fetched_word, 32'h4444_4444);
      do_req(32'h40, LOAD, 32'h0, lat);
      chk("after_clflush", l2_fetched_word, 32'hDEAD_BEEF);

      // valid held high through 8 consecutive loads
      for (int k = 0; k < 8; k++) do_req(32'(4 * k), STORE, 32'hA0 + 32'(k), lat);
      @(posedge clk); #1 drive(32'h0, LOAD, 32'h0);
      strobes = 0; t_prev = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         wait_strobe(lat);
         t_now = $time;
         if (l2_fetched_word_valid) strobes++;
         chk("stream_data", l2_fetched_word, 32'hA0 + 32'(k));
         if (k > 0) chk("stream_gap_min", ((t_now - t_prev) / 10) >= LATENCY + 1, 1);
         t_prev = t_now;
         @(posedge clk); #1;
         if (k < 7) l2_req_address = 32'(4 * (k + 1)); else l2_req_valid = 1'b0;
      end
      chk("stream_strobes", strobes, 8);
      chk("stream_perr", protocol_error, 0);

      // address moved during WAIT: sticky error, data from the captured address
      @(posedge clk); #1 drive(32'h40, LOAD, 32'h0);
      @(posedge clk); #1 l2_req_address = 32'h44;
      wait_strobe(lat);
      chk("violation_data", l2_fetched_word, 32'hDEAD_BEEF);
      chk("violation_perr", protocol_error, 1);
      @(posedge clk); #1 l2_req_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("perr_sticky", protocol_error, 1);

      // reset two edges into a STORE aborts it
      do_req(32'h80, STORE, 32'h1111_0000, lat);
      @(posedge clk); #1 drive(32'h80, STORE, 32'h1234_5678);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_valid", l2_fetched_word_valid, 0);
      chk("abort_fetched", l2_fetched_word, 0);
      chk("abort_perr", protocol_error, 0);
      l2_req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      do_req(32'h80, LOAD, 32'h0, lat);
      chk("abort_kept", l2_fetched_word, 32'h1111_0000);

      // randomized traffic, occasional violations and back-to-back requests
      @(posedge clk); #1;
      for (int n = 0; n < 120; n++) begin
         ra = $urandom & 32'hFFFF_F03F;
         rt = memory_operation_e'($urandom_range(0, 2));
         drive(ra, rt, $urandom);
         @(posedge clk);
         if ($urandom_range(0, 7) == 0) begin
            #1;
            if ($urandom_range(0, 1) == 0) l2_req_address = l2_req_address ^ 32'h4;
            else l2_req_valid = 1'b0;
         end
         wait_strobe(lat);
         @(posedge clk); #1 l2_req_valid = 1'b0;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("final_reset_perr", protocol_error, 0);
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
